// File: rtl/quant_pkg.sv
// Shared constants for the streaming JPEG quantizer.
// Inverse tables hold round(65536/q) of the standard luma/chroma steps.
package quant_pkg;

    localparam int QBLK   = 64;
    localparam int FRAC_W = 16;
    localparam int COEF_W = 32;

    localparam logic signed [63:0] HALF_LSB = 64'sd32768;

    typedef logic [31:0] qinv_tab_t [QBLK];

    localparam qinv_tab_t LUMA_QINV = '{
        4096, 5958, 6554, 4096, 2731, 1638, 1285, 1074,
        5461, 5461, 4681, 3449, 2521, 1130, 1092, 1192,
        4681, 5041, 4096, 2731, 1638, 1150,  950, 1170,
        4681, 3855, 2979, 2260, 1285,  753,  819, 1057,
        3641, 2979, 1771, 1170,  964,  601,  636,  851,
        2731, 1872, 1192, 1024,  809,  630,  580,  712,
        1337, 1024,  840,  753,  636,  542,  546,  649,
         910,  712,  690,  669,  585,  655,  636,  662
    };

    localparam qinv_tab_t CHROMA_QINV = '{
        3855, 3641, 2731, 1394,  662,  662,  662,  662,
        3641, 3121, 2521,  993,  662,  662,  662,  662,
        2731, 2521, 1170,  662,  662,  662,  662,  662,
        1394,  993,  662,  662,  662,  662,  662,  662,
         662,  662,  662,  662,  662,  662,  662,  662,
         662,  662,  662,  662,  662,  662,  662,  662,
         662,  662,  662,  662,  662,  662,  662,  662,
         662,  662,  662,  662,  662,  662,  662,  662
    };

endpackage

// File: rtl/quant_lane.sv
// One quantizer lane: S1 holds the Q16.16 x Q16.16 product,
// S2 holds the rounded and saturated integer.
module quant_lane
    import quant_pkg::*;
#(
    parameter int OUT_W      = 12,
    parameter int ROUND_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ld1,
    input  logic              i_ld2,
    input  logic [COEF_W-1:0] i_data,
    input  logic [31:0]       i_inv,
    output logic [OUT_W-1:0]  o_data,
    output logic              o_sat
);

    localparam logic signed [63:0] MAX_V = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    localparam logic signed [63:0] MIN_V = -(64'sd1 <<< (OUT_W - 1));

    logic signed [63:0] w_prod;
    logic signed [63:0] r_prod;
    logic signed [63:0] w_val;
    logic signed [63:0] w_mag;
    logic signed [63:0] w_rmag;
    logic signed [63:0] w_int;
    logic               w_neg;
    logic               w_sat;
    logic [OUT_W-1:0]   w_q;
    logic [OUT_W-1:0]   r_data;
    logic               r_sat;

    assign w_prod = $signed({{32{i_data[COEF_W-1]}}, i_data})
                  * $signed({32'd0, i_inv});

    always_comb begin
        w_val  = r_prod >>> FRAC_W;
        w_neg  = w_val[63];
        w_mag  = w_neg ? -w_val : w_val;
        w_rmag = (w_mag + HALF_LSB) >>> FRAC_W;
        if (ROUND_MODE != 0) begin
            w_int = w_neg ? -w_rmag : w_rmag;
        end else begin
            w_int = w_val >>> FRAC_W;
        end
        w_sat = 1'b0;
        w_q   = w_int[OUT_W-1:0];
        if (w_int > MAX_V) begin
            w_q   = MAX_V[OUT_W-1:0];
            w_sat = 1'b1;
        end else if (w_int < MIN_V) begin
            w_q   = MIN_V[OUT_W-1:0];
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod <= '0;
            r_data <= '0;
            r_sat  <= 1'b0;
        end else begin
            if (i_ld1) begin
                r_prod <= w_prod;
            end
            if (i_ld2) begin
                r_data <= w_q;
                r_sat  <= w_sat;
            end
        end
    end

    assign o_data = r_data;
    assign o_sat  = r_sat;

endmodule

// File: rtl/quantize_stream.sv
// Two-stage streaming quantizer: LANES coefficients per beat,
// block framing from a local counter, sticky framing error.
module quantize_stream
    import quant_pkg::*;
#(
    parameter int LANES      = 8,
    parameter int OUT_W      = 12,
    parameter int ROUND_MODE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [32*LANES-1:0]    in_data,
    input  logic                   in_chroma,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W*LANES-1:0] out_data,
    output logic [5:0]             out_idx,
    output logic                   out_last,
    output logic [LANES-1:0]       out_sat,
    output logic                   err
);

    localparam logic [5:0] LAST_IDX = 6'(QBLK - LANES);
    localparam logic [5:0] STEP     = 6'(LANES);

    logic [5:0] r_idx;
    logic       r_chroma;
    logic       r_s1_valid;
    logic [5:0] r_s1_idx;
    logic       r_s1_last;
    logic       r_s2_valid;
    logic [5:0] r_out_idx;
    logic       r_out_last;
    logic       r_err;

    logic w_ld1;
    logic w_ld2;
    logic w_ld2_data;
    logic w_acc;
    logic w_at_last;
    logic w_csel;

    assign w_ld2      = !r_s2_valid || out_ready;
    assign w_ld1      = !r_s1_valid || w_ld2;
    assign w_acc      = in_valid && w_ld1;
    assign w_ld2_data = w_ld2 && r_s1_valid;
    assign w_at_last  = (r_idx == LAST_IDX);
    // The first beat of a block selects its table before r_chroma is loaded
    assign w_csel     = (r_idx == 6'd0) ? in_chroma : r_chroma;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= '0;
            r_chroma <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_acc) begin
            r_idx <= (in_last || w_at_last) ? 6'd0 : r_idx + STEP;
            if (r_idx == 6'd0) begin
                r_chroma <= in_chroma;
            end
            if (in_last != w_at_last) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_last  <= 1'b0;
        end else begin
            if (w_ld1) begin
                r_s1_valid <= in_valid;
            end
            if (w_acc) begin
                r_s1_idx  <= r_idx;
                r_s1_last <= w_at_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_out_idx  <= '0;
            r_out_last <= 1'b0;
        end else begin
            if (w_ld2) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_ld2_data) begin
                r_out_idx  <= r_s1_idx;
                r_out_last <= r_s1_last;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [5:0]  w_tidx;
        logic [31:0] w_inv;

        assign w_tidx = r_idx + 6'(k);
        assign w_inv  = w_csel ? CHROMA_QINV[w_tidx] : LUMA_QINV[w_tidx];

        quant_lane #(
            .OUT_W      (OUT_W),
            .ROUND_MODE (ROUND_MODE)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_ld1  (w_acc),
            .i_ld2  (w_ld2_data),
            .i_data (in_data[32*k +: 32]),
            .i_inv  (w_inv),
            .o_data (out_data[OUT_W*k +: OUT_W]),
            .o_sat  (out_sat[k])
        );
    end

    assign in_ready  = w_ld1;
    assign out_valid = r_s2_valid;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign err       = r_err;

endmodule

// File: tb/tb_quantize_stream.sv
// Directed bench for quantize_stream: a round-half-away 12-bit
// instance and a truncating 8-bit instance share one input stream.
module tb_quantize_stream;

    localparam int L = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_chroma = 1'b0;
    logic         in_last = 1'b0;
    logic         out_ready = 1'b1;
    logic [255:0] in_data = '0;

    logic         in_ready;
    logic         rdy1;
    logic         v0, v1;
    logic [95:0]  od0;
    logic [63:0]  od1;
    logic [5:0]   ix0, ix1;
    logic         last0, last1;
    logic [7:0]   s0, s1;
    logic         err0, err1;

    int n_tot = 0;
    int n_bad = 0;
    int cyc = 0;
    bit tog_en = 1'b0;

    logic [5:0]  q_idx [$];
    logic        q_last [$];
    logic [95:0] q_d0 [$];
    logic [63:0] q_d1 [$];
    logic [7:0]  q_s0 [$];
    logic [7:0]  q_s1 [$];
    int          q_cyc [$];

    int LQ [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };
    int CQ [64] = '{
        17, 18, 24, 47, 99, 99, 99, 99,
        18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,
        47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99
    };

    quantize_stream #(.LANES(L), .OUT_W(12), .ROUND_MODE(1)) u_d0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_chroma(in_chroma), .in_last(in_last),
        .out_valid(v0), .out_ready(out_ready), .out_data(od0),
        .out_idx(ix0), .out_last(last0), .out_sat(s0), .err(err0)
    );

    quantize_stream #(.LANES(L), .OUT_W(8), .ROUND_MODE(0)) u_d1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .in_chroma(in_chroma), .in_last(in_last),
        .out_valid(v1), .out_ready(out_ready), .out_data(od1),
        .out_idx(ix1), .out_last(last1), .out_sat(s1), .err(err1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(negedge clk);
        if (tog_en) out_ready = ~out_ready;
    end

    always begin
        @(negedge clk);
        #4;
        if (!rst && v0 && out_ready) begin
            q_idx.push_back(ix0);
            q_last.push_back(last0);
            q_d0.push_back(od0);
            q_d1.push_back(od1);
            q_s0.push_back(s0);
            q_s1.push_back(s1);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [127:0] got,
                       input logic signed [127:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int lv0(input logic [95:0] d, input int k);
        return int'($signed(d[k*12 +: 12]));
    endfunction

    function automatic int lv1(input logic [63:0] d, input int k);
        return int'($signed(d[k*8 +: 8]));
    endfunction

    function automatic logic [255:0] mk_beat(input int kind, input int b);
        logic [255:0] d;
        int i, q;
        d = '0;
        for (int k = 0; k < L; k++) begin
            i = b * L + k;
            case (kind)
                0: begin
                    if (b == 0 && k == 0) d[k*32 +: 32] = 32'h0028_0000;
                    if (b == 0 && k == 3) d[k*32 +: 32] = 32'hFFD8_0000;
                end
                1: begin
                    if (b == 0 && k == 0) d[k*32 +: 32] = 32'h7FFF_0000;
                    if (b == 0 && k == 3) d[k*32 +: 32] = 32'h8001_0000;
                end
                default: begin
                    // (i + 1.25) * q, so either table rounds to i + 1
                    q = (kind == 3) ? CQ[i] : LQ[i];
                    d[k*32 +: 32] = 32'((4 * i + 5) * q * 16384);
                end
            endcase
        end
        return d;
    endfunction

    task automatic send_beat(input logic [255:0] d, input logic ch,
                             input logic lst, output int acc);
        int  n;
        bit  ok;
        n = 0;
        ok = 1'b0;
        acc = -1;
        in_valid = 1'b1;
        in_data = d;
        in_chroma = ch;
        in_last = lst;
        while (!ok && n < 40) begin
            #4;
            if (in_ready) begin
                ok = 1'b1;
                acc = cyc;
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!ok) chk("accept", 0, 1);
    endtask

    task automatic send_block(input int kind, input logic chf,
                              input logic chr, output int a0, output int a7);
        int a;
        a0 = -1;
        a7 = -1;
        for (int b = 0; b < 8; b++) begin
            send_beat(mk_beat(kind, b), (b == 0) ? chf : chr, b == 7, a);
            if (b == 0) a0 = a;
            if (b == 7) a7 = a;
        end
    endtask

    task automatic drain(input int target, input string tag);
        int n;
        n = 0;
        while (q_idx.size() < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_count"}, q_idx.size(), target);
    endtask

    task automatic check_ramp(input int base, input string tag);
        logic [95:0] e0;
        logic [63:0] e1;
        for (int j = 0; j < 8; j++) begin
            e0 = '0;
            e1 = '0;
            for (int k = 0; k < L; k++) begin
                e0[k*12 +: 12] = 12'(j * 8 + k + 1);
                e1[k*8 +: 8] = 8'(j * 8 + k + 1);
            end
            chk({tag, "_idx"}, q_idx[base+j], j * 8);
            chk({tag, "_last"}, q_last[base+j], j == 7);
            chk({tag, "_d0"}, q_d0[base+j], e0);
            chk({tag, "_d1"}, q_d1[base+j], e1);
            chk({tag, "_sat"}, {q_s0[base+j], q_s1[base+j]}, 0);
        end
    endtask

    int base, a0, a7, a;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", v0, 0);
        chk("rst_data0", od0, 0);
        chk("rst_data1", od1, 0);
        chk("rst_idx", ix0, 0);
        chk("rst_last", last0, 0);
        chk("rst_sat", s0, 0);
        chk("rst_err", err0, 0);
        rst = 1'b0;
        #4;
        chk("rst_ready", in_ready, 1);
        @(negedge clk);

        base = q_idx.size();
        send_block(0, 1'b0, 1'b0, a0, a7);
        drain(base + 8, "A");
        chk("A_d0_pos", lv0(q_d0[base], 0), 3);
        chk("A_d1_pos", lv1(q_d1[base], 0), 2);
        chk("A_d0_neg", lv0(q_d0[base], 3), -3);
        chk("A_d1_neg", lv1(q_d1[base], 3), -3);
        chk("A_idx0", q_idx[base], 0);
        chk("A_latency", q_cyc[base] - a0, 2);
        chk("A_thruput", a7 - a0, 7);
        chk("A_last6", q_last[base+6], 0);
        chk("A_last7", q_last[base+7], 1);

        base = q_idx.size();
        send_block(1, 1'b0, 1'b0, a0, a7);
        drain(base + 8, "B");
        chk("B_d0_max", lv0(q_d0[base], 0), 2047);
        chk("B_d0_min", lv0(q_d0[base], 3), -2048);
        chk("B_d0_sat", q_s0[base], 8'h01);
        chk("B_d1_max", lv1(q_d1[base], 0), 127);
        chk("B_d1_min", lv1(q_d1[base], 3), -128);
        chk("B_d1_sat", q_s1[base], 8'h09);

        base = q_idx.size();
        tog_en = 1'b1;
        send_block(2, 1'b0, 1'b1, a0, a7);
        drain(base + 8, "C");
        tog_en = 1'b0;
        out_ready = 1'b1;
        check_ramp(base, "C");

        base = q_idx.size();
        send_block(3, 1'b1, 1'b0, a0, a7);
        drain(base + 8, "D");
        check_ramp(base, "D");

        base = q_idx.size();
        send_block(2, 1'b0, 1'b0, a0, a7);
        drain(base + 8, "E");
        check_ramp(base, "E");

        chk("F_err_pre", err0, 0);
        base = q_idx.size();
        for (int b = 0; b < 4; b++) begin
            send_beat(mk_beat(2, b), 1'b0, b == 3, a);
        end
        chk("F_err0", err0, 1);
        chk("F_err1", err1, 1);
        send_block(2, 1'b0, 1'b0, a0, a7);
        drain(base + 12, "F");
        chk("F_idx3", q_idx[base+3], 24);
        chk("F_last3", q_last[base+3], 0);
        check_ramp(base + 4, "F");
        chk("F_err_sticky", err0, 1);

        out_ready = 1'b0;
        send_beat(mk_beat(2, 0), 1'b0, 1'b0, a);
        send_beat(mk_beat(2, 1), 1'b0, 1'b0, a);
        chk("G_hold_valid", v0, 1);
        chk("G_hold_idx", ix0, 0);
        #4;
        chk("G_stall_ready", in_ready, 0);
        @(negedge clk);
        chk("G_hold_idx2", ix0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("G_rst_valid", v0, 0);
        chk("G_rst_err", err0, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        base = q_idx.size();
        send_block(2, 1'b0, 1'b0, a0, a7);
        drain(base + 8, "G");
        check_ramp(base, "G");

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/quantize_stream.md
# quantize_stream

Streaming, pipelined JPEG quantizer: accepts 8x8 DCT coefficient blocks (signed Q16.16) as `LANES` coefficients per beat over a valid/ready handshake, multiplies each by the per-index inverse quantization step (luma or chroma, selected per block at run time), rounds, and saturates to a signed `OUT_W`-bit integer. It replaces the fixed-table, all-combinational 64-wide quantizer between the DCT stage and the zig-zag/entropy stage, trading width for throughput and adding flow control, block framing and error detection.

## Interface
- `LANES`, 8: coefficients per beat; power of two, 1..64; one block = 64/`LANES` beats.
- `OUT_W`, 12: output integer width, 8..16.
- `ROUND_MODE`, 1: 0 = truncate toward −inf (arithmetic shift); 1 = round half away from zero.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `in_data`  in  32*LANES  lane k = coefficient index `idx+k`, signed Q16.16.
- `in_chroma`  in  1  table select (0 luma, 1 chroma); sampled only on the first beat of a block.
- `in_last`  in  1  producer's end-of-block marker.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  OUT_W*LANES  quantized signed integers, same lane order as input.
- `out_idx`  out  6  coefficient index of lane 0.
- `out_last`  out  1  counter-generated end-of-block (`out_idx == 64-LANES`).
- `out_sat`  out  LANES  per-lane saturation occurred.
- `err`  out  1  sticky framing error.

## Operation
- Beat counter `idx` (6 bits) starts at 0 and advances by `LANES` per accepted beat, wrapping at 64 to 0.
- On the accepted beat with `idx==0`, `in_chroma` is latched for the whole block; changes mid-block are ignored.
- Per lane: product = signed(`in_data`) × unsigned inverse entry (Q16.16, ≤ 0x00010000), 64-bit signed; value = product >>> 16 (Q16.16).
- Rounding: mode 0 takes value >>> 16. Mode 1 adds 0x8000 to the magnitude, then truncates and restores the sign (half away from zero).
- Saturation: clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1]; set the lane's `out_sat` when clamped.
- Framing: if `in_last` on an accepted beat disagrees with (`idx==64-LANES`), set `err` (cleared only by `rst`). If `in_last` is asserted early, `idx` resyncs to 0 after that beat. Output framing always follows the counter.
- Reset mid-block: the block is discarded, the pipeline is emptied, and `idx` returns to 0.

## Timing
- Two-stage pipeline: S1 registers the products plus idx/chroma/last; S2 registers the rounded, saturated results.
- Latency: accepted beat to `out_valid` is 2 cycles. Throughput is 1 beat/cycle while `out_ready` stays high.
- S2 loads when `!s2_valid || out_ready`. S1 loads when `!s1_valid || S2 loads`. `in_ready` = `!s1_valid || S2 loads` (combinational from `out_ready`, no skid buffer).
- `out_*` hold stable while `out_valid && !out_ready`.
- Reset values: `out_valid` 0, `out_data` 0, `out_idx` 0, `out_last` 0, `out_sat` 0, `err` 0. `in_ready` is 1 from the first cycle after reset release.

## Structure
- Package `quant_pkg`:
  - `LUMA_QINV` / `CHROMA_QINV`: 64×32-bit constants, round(65536/q) of the standard JPEG tables.
  - `QBLK = 64`.
  - Q-format constants (`FRAC_W = 16`).
- Sub-module `quant_lane`: one multiply/round/saturate lane, instantiated `LANES` times. The top holds the counter, table mux, handshake and error logic.

## Test plan
- LANES=8, luma, pixel 0x00280000 (40.0) at idx 0 (q=16) -> mode 1 gives 3, mode 0 gives 2. Pixel −40.0 -> −3 in both modes.
- OUT_W=8, pixel 0x7FFF0000 at idx 0 luma -> out 127, `out_sat[0]`=1. Same pixel negated -> −128.
- Full block, 8 beats, `out_ready` toggled 1/0 every cycle -> all 64 results in order; `out_last` only on `out_idx`=56; no beat lost or duplicated.
- `in_chroma` 1 on beat 0 then 0 on beats 1–7 -> whole block uses the chroma table. The next block, started with 0, uses luma.
- `in_last` on beat 3 -> `err`=1; the next beat is treated as `idx` 0; `err` stays 1 until `rst`.
- `rst` pulsed with 2 beats in flight -> `out_valid` drops immediately; the next block starts at `out_idx` 0.
